// File: rtl/gemm_pkg.sv
// Shared types, default widths and tiling helper for the multilane GEMM engine.
package gemm_pkg;

  localparam int DATA_W_A  = 8;
  localparam int DATA_W_B  = 8;
  localparam int DATA_W_C  = 32;
  localparam int NUM_LANES = 4;
  localparam int ADDR_W    = 12;
  localparam int SIZE_W    = 12;

  typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_e;

  function automatic logic [31:0] ceil_div(input logic [31:0] num, input logic [31:0] den);
    return (num + den - 32'd1) / den;
  endfunction

endpackage

// File: rtl/gemm_accelerator_multilane_if.sv
// SRAM A/B/C port bundle: A element read, lane-packed B read, lane-packed C write with per-lane enables.
interface gemm_accelerator_multilane_if
  import gemm_pkg::*;
#(
  parameter int DataWidthA     = DATA_W_A,
  parameter int DataWidthB     = DATA_W_B,
  parameter int DataWidthC     = DATA_W_C,
  parameter int NumLanes       = NUM_LANES,
  parameter int SRAMAddrWidthA = ADDR_W,
  parameter int SRAMAddrWidthB = ADDR_W,
  parameter int SRAMAddrWidthC = ADDR_W
);
  logic [SRAMAddrWidthA-1:0]      a_addr;
  logic [DataWidthA-1:0]          a_rdata;
  logic [SRAMAddrWidthB-1:0]      b_addr;
  logic [NumLanes*DataWidthB-1:0] b_rdata;
  logic [SRAMAddrWidthC-1:0]      c_addr;
  logic [NumLanes*DataWidthC-1:0] c_wdata;
  logic [NumLanes-1:0]            c_we;

  modport master (
    output a_addr, b_addr, c_addr, c_wdata, c_we,
    input  a_rdata, b_rdata
  );

  modport slave (
    input  a_addr, b_addr, c_addr, c_wdata, c_we,
    output a_rdata, b_rdata
  );
endinterface

// File: rtl/gemm_mac_lane.sv
// One output column: signed multiply-accumulate register, wraps modulo 2^DataWidthC.
// Single-cycle update; clr_i has priority over en_i.
module gemm_mac_lane #(
  parameter int DataWidthA = 8,
  parameter int DataWidthB = 8,
  parameter int DataWidthC = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clr_i,
  input  logic                         en_i,
  input  logic signed [DataWidthA-1:0] a_i,
  input  logic signed [DataWidthB-1:0] b_i,
  output logic        [DataWidthC-1:0] acc_o
);
  localparam int ProdWidth = DataWidthA + DataWidthB;

  logic signed [ProdWidth-1:0]  prod;
  logic signed [DataWidthC-1:0] prod_c;
  logic        [DataWidthC-1:0] acc_q, acc_d;

  assign prod   = a_i * b_i;
  // Sign-extends or truncates the product to the accumulator width.
  assign prod_c = DataWidthC'(prod);

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + prod_c;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;
endmodule

// File: rtl/gemm_accelerator_multilane.sv
// Signed GEMM C = A*B over NumLanes-wide column tiles; K MAC cycles plus one WRITE cycle per tile.
// Start-accept to done_o: M*ceil(N/NumLanes)*(K+1) cycles; start_i ignored while busy.
module gemm_accelerator_multilane
  import gemm_pkg::*;
#(
  parameter int DataWidthA     = DATA_W_A,
  parameter int DataWidthB     = DATA_W_B,
  parameter int DataWidthC     = DATA_W_C,
  parameter int NumLanes       = NUM_LANES,
  parameter int SRAMAddrWidthA = ADDR_W,
  parameter int SRAMAddrWidthB = ADDR_W,
  parameter int SRAMAddrWidthC = ADDR_W,
  parameter int SizeWidth      = SIZE_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [SizeWidth-1:0] M_size_i,
  input  logic [SizeWidth-1:0] K_size_i,
  input  logic [SizeWidth-1:0] N_size_i,
  gemm_accelerator_multilane_if.master sram,
  output logic                 busy_o,
  output logic                 done_o
);
  localparam logic [SizeWidth-1:0] OneS = SizeWidth'(1);
  localparam int SizeWidth1 = SizeWidth + 1;

  state_e state_q, state_d;
  logic [SizeWidth-1:0] m_size_q, m_size_d, k_size_q, k_size_d, n_size_q, n_size_d;
  logic [SizeWidth-1:0] m_q, m_d, t_q, t_d, k_q, k_d, t_last_q, t_last_d, n0_q, n0_d;
  logic [SRAMAddrWidthA-1:0] a_base_q, a_base_d, a_addr_q, a_addr_d;
  logic [SRAMAddrWidthB-1:0] b_addr_q, b_addr_d;
  logic [SRAMAddrWidthC-1:0] c_row_q, c_row_d;
  logic                      acc_clr, acc_en;
  logic [NumLanes-1:0]       we;
  logic [NumLanes*DataWidthC-1:0] acc;

  always_comb begin
    state_d  = state_q;
    m_size_d = m_size_q;
    k_size_d = k_size_q;
    n_size_d = n_size_q;
    m_d      = m_q;
    t_d      = t_q;
    k_d      = k_q;
    t_last_d = t_last_q;
    n0_d     = n0_q;
    a_base_d = a_base_q;
    a_addr_d = a_addr_q;
    b_addr_d = b_addr_q;
    c_row_d  = c_row_q;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          m_size_d = M_size_i;
          k_size_d = K_size_i;
          n_size_d = N_size_i;
          m_d      = '0;
          t_d      = '0;
          k_d      = '0;
          n0_d     = '0;
          a_base_d = '0;
          a_addr_d = '0;
          b_addr_d = '0;
          c_row_d  = '0;
          t_last_d = SizeWidth'(ceil_div(32'(N_size_i), 32'(NumLanes)) - 32'd1);
          acc_clr  = 1'b1;
          state_d  = (M_size_i == '0 || K_size_i == '0 || N_size_i == '0) ? DONE : MAC;
        end
      end
      MAC: begin
        acc_en   = 1'b1;
        k_d      = k_q + OneS;
        a_addr_d = a_addr_q + SRAMAddrWidthA'(1);
        b_addr_d = b_addr_q + SRAMAddrWidthB'(n_size_q);
        if (k_q == k_size_q - OneS) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        acc_clr = 1'b1;
        k_d     = '0;
        state_d = MAC;
        if (t_q == t_last_q) begin
          // Row finished: rewind to tile 0 and step A/C row bases.
          t_d      = '0;
          n0_d     = '0;
          m_d      = m_q + OneS;
          a_base_d = a_base_q + SRAMAddrWidthA'(k_size_q);
          a_addr_d = a_base_q + SRAMAddrWidthA'(k_size_q);
          c_row_d  = c_row_q + SRAMAddrWidthC'(n_size_q);
          b_addr_d = '0;
          if (m_q == m_size_q - OneS) begin
            state_d = DONE;
          end
        end else begin
          t_d      = t_q + OneS;
          n0_d     = n0_q + SizeWidth'(NumLanes);
          a_addr_d = a_base_q;
          b_addr_d = SRAMAddrWidthB'(n0_q) + SRAMAddrWidthB'(NumLanes);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      m_size_q <= '0;
      k_size_q <= '0;
      n_size_q <= '0;
      m_q      <= '0;
      t_q      <= '0;
      k_q      <= '0;
      t_last_q <= '0;
      n0_q     <= '0;
      a_base_q <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      c_row_q  <= '0;
    end else begin
      state_q  <= state_d;
      m_size_q <= m_size_d;
      k_size_q <= k_size_d;
      n_size_q <= n_size_d;
      m_q      <= m_d;
      t_q      <= t_d;
      k_q      <= k_d;
      t_last_q <= t_last_d;
      n0_q     <= n0_d;
      a_base_q <= a_base_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
      c_row_q  <= c_row_d;
    end
  end

  // Lanes whose column index reaches N are masked off on the partial last tile.
  always_comb begin
    we = '0;
    if (state_q == WRITE) begin
      for (int l = 0; l < NumLanes; l++) begin
        we[l] = ({1'b0, n0_q} + SizeWidth1'(l)) < {1'b0, n_size_q};
      end
    end
  end

  for (genvar gl = 0; gl < NumLanes; gl++) begin : g_lane
    gemm_mac_lane #(
      .DataWidthA(DataWidthA),
      .DataWidthB(DataWidthB),
      .DataWidthC(DataWidthC)
    ) u_lane (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .clr_i (acc_clr),
      .en_i  (acc_en),
      .a_i   (sram.a_rdata),
      .b_i   (sram.b_rdata[gl*DataWidthB +: DataWidthB]),
      .acc_o (acc[gl*DataWidthC +: DataWidthC])
    );
  end

  assign sram.a_addr  = a_addr_q;
  assign sram.b_addr  = b_addr_q;
  assign sram.c_addr  = c_row_q + SRAMAddrWidthC'(n0_q);
  assign sram.c_wdata = acc;
  assign sram.c_we    = we;
  assign busy_o       = (state_q == MAC) || (state_q == WRITE);
  assign done_o       = (state_q == DONE);
endmodule

// File: tb/tb_gemm_accelerator_multilane.sv
// Runs a 32-bit and a 16-bit accumulator instance side by side against an arithmetic GEMM reference.
module tb_gemm_accelerator_multilane;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] m_size, k_size, n_size;
  logic        busy32, done32, busy16, done16;
  logic        clr_req = 1'b0;

  logic [7:0]  mem_a   [4096];
  logic [7:0]  mem_b   [4096];
  logic [31:0] mem_c   [4096];
  logic [15:0] mem_c16 [4096];
  int          gold    [4096];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gemm_accelerator_multilane_if #(.DataWidthC(32)) sif32 ();
  gemm_accelerator_multilane_if #(.DataWidthC(16)) sif16 ();

  gemm_accelerator_multilane #(.DataWidthC(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .M_size_i(m_size), .K_size_i(k_size), .N_size_i(n_size),
    .sram(sif32), .busy_o(busy32), .done_o(done32)
  );

  gemm_accelerator_multilane #(.DataWidthC(16)) dut16 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .M_size_i(m_size), .K_size_i(k_size), .N_size_i(n_size),
    .sram(sif16), .busy_o(busy16), .done_o(done16)
  );

  assign sif32.a_rdata = mem_a[sif32.a_addr];
  assign sif16.a_rdata = mem_a[sif16.a_addr];

  always_comb begin
    for (int l = 0; l < 4; l++) begin
      sif32.b_rdata[l*8 +: 8] = mem_b[sif32.b_addr + 12'(l)];
      sif16.b_rdata[l*8 +: 8] = mem_b[sif16.b_addr + 12'(l)];
    end
  end

  always @(posedge clk) begin
    if (clr_req) begin
      for (int i = 0; i < 4096; i++) begin
        mem_c[i]   <= 32'hDEADBEEF;
        mem_c16[i] <= 16'hBEEF;
      end
    end else begin
      for (int l = 0; l < 4; l++) begin
        if (sif32.c_we[l]) mem_c[sif32.c_addr + 12'(l)] <= sif32.c_wdata[l*32 +: 32];
        if (sif16.c_we[l]) mem_c16[sif16.c_addr + 12'(l)] <= sif16.c_wdata[l*16 +: 16];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic reset_checks(input string tag);
    check_eq({tag, "_busy"}, {31'b0, busy32}, 0);
    check_eq({tag, "_done"}, {31'b0, done32}, 0);
    check_eq({tag, "_we"}, {28'b0, sif32.c_we}, 0);
    check_eq({tag, "_a_addr"}, {20'b0, sif32.a_addr}, 0);
    check_eq({tag, "_b_addr"}, {20'b0, sif32.b_addr}, 0);
    check_eq({tag, "_c_addr"}, {20'b0, sif32.c_addr}, 0);
    check_eq({tag, "_wdata"}, {31'b0, |sif32.c_wdata}, 0);
    check_eq({tag, "_done16"}, {31'b0, done16}, 0);
    check_eq({tag, "_wdata16"}, {31'b0, |sif16.c_wdata}, 0);
  endtask

  // mode 0: random, 1: all -128, 2: random with A[0]=127, B[0]=-128
  task automatic fill(input int mode);
    for (int i = 0; i < 4096; i++) begin
      mem_a[i] = (mode == 1) ? 8'h80 : 8'($urandom);
      mem_b[i] = (mode == 1) ? 8'h80 : 8'($urandom);
    end
    if (mode == 2) begin
      mem_a[0] = 8'h7F;
      mem_b[0] = 8'h80;
    end
    @(negedge clk) clr_req = 1'b1;
    @(negedge clk) clr_req = 1'b0;
  endtask

  task automatic run(input int M, input int K, input int N, input int poke_at, input string tag);
    int T, lat, cycles, wi;
    logic [11:0] ea[$];
    logic [3:0]  ew[$];
    logic [3:0]  mask;
    T   = (N + 3) / 4;
    lat = M * T * (K + 1);
    for (int m = 0; m < M; m++) begin
      for (int t = 0; t < T; t++) begin
        mask = '0;
        for (int l = 0; l < 4; l++) if (t*4 + l < N) mask[l] = 1'b1;
        ea.push_back(12'(m*N + t*4));
        ew.push_back(mask);
      end
    end
    for (int i = 0; i < 4096; i++) gold[i] = 32'hDEADBEEF;
    for (int m = 0; m < M; m++) begin
      for (int n = 0; n < N; n++) begin
        int acc;
        acc = 0;
        for (int k = 0; k < K; k++) begin
          int av, bv;
          av = $signed(mem_a[m*K + k]);
          bv = $signed(mem_b[k*N + n]);
          acc += av * bv;
        end
        gold[m*N + n] = acc;
      end
    end

    m_size = 12'(M); k_size = 12'(K); n_size = 12'(N);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (lat > 0) begin
      check_eq({tag, "_busy_after_start"}, {31'b0, busy32}, 1);
      check_eq({tag, "_done_drop"}, {31'b0, done32}, 0);
    end
    cycles = 0;
    wi     = 0;
    while (!done32 && cycles < lat + 16) begin
      if (sif32.c_we != '0) begin
        if (wi < ea.size()) begin
          check_eq({tag, "_c_addr"}, {20'b0, sif32.c_addr}, {20'b0, ea[wi]});
          check_eq({tag, "_we"}, {28'b0, sif32.c_we}, {28'b0, ew[wi]});
        end else begin
          check_eq({tag, "_we_extra"}, {28'b0, sif32.c_we}, 0);
        end
        wi++;
      end
      if (cycles == poke_at) begin
        start = 1'b1;
        m_size = 12'd7; k_size = 12'd7; n_size = 12'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1 cycles++;
    end
    start = 1'b0;
    check_eq({tag, "_latency"}, cycles, lat);
    check_eq({tag, "_done"}, {31'b0, done32}, 1);
    check_eq({tag, "_done16"}, {31'b0, done16}, 1);
    check_eq({tag, "_busy_end"}, {31'b0, busy32}, 0);
    check_eq({tag, "_we_in_done"}, {28'b0, sif32.c_we}, 0);
    check_eq({tag, "_write_count"}, wi, ea.size());
    for (int i = 0; i < M*N + 8; i++) begin
      check_eq({tag, "_c32"}, mem_c[i], $unsigned(gold[i]));
      check_eq({tag, "_c16"}, {16'b0, mem_c16[i]}, {16'b0, gold[i][15:0]});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    m_size = '0; k_size = '0; n_size = '0;
    #12;
    reset_checks("por");
    @(negedge clk) rst_n = 1'b1;

    fill(2);
    run(1, 1, 1, -1, "t1");
    check_eq("t1_c0_value", mem_c[0], 32'hFFFFC080);

    fill(0);
    run(2, 3, 4, -1, "t2");
    run(3, 2, 5, -1, "t3");

    fill(1);
    run(1, 32, 4, -1, "t4");
    check_eq("t4_c32_value", mem_c[3], 32'h00080000);
    check_eq("t4_c16_wrap", {16'b0, mem_c16[3]}, 32'h0);

    fill(0);
    run(3, 3, 0, -1, "t5_zero_n");
    run(2, 2, 2, -1, "t5_restart");

    fill(0);
    m_size = 12'd32; k_size = 12'd32; n_size = 12'd32;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (100) @(posedge clk);
    check_eq("t6_busy_before_rst", {31'b0, busy32}, 1);
    #3 rst_n = 1'b0;
    #1 reset_checks("t6_midrun_rst");
    @(negedge clk) rst_n = 1'b1;
    fill(0);
    run(4, 5, 6, 3, "t6_fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/gemm_accelerator_multilane.md
Name: gemm_accelerator_multilane

Overview:
Next-generation signed GEMM engine. It computes C[M×N] = A[M×K] · B[K×N] with NumLanes parallel MAC lanes. Each lane owns one output column of an N-tile. It reads A (row-major, one element per cycle) and a wide B word (NumLanes consecutive row elements), and writes a wide C word with per-lane write enables. It sits in the same slot as the single-lane accelerator top: start/done control, M/K/N runtime sizes, and SRAM A/B/C ports.

Parameters:
DataWidthA, 8, A element width (signed)
DataWidthB, 8, B element width (signed)
DataWidthC, 32, accumulator/C element width (signed)
NumLanes, 4, parallel output columns per tile (≥1)
SRAMAddrWidthA, 12, A element address width
SRAMAddrWidthB, 12, B element address width
SRAMAddrWidthC, 12, C element address width
SizeWidth, 12, width of M/K/N size inputs

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
start_i  in  1  start request, sampled in IDLE/DONE
M_size_i  in  SizeWidth  rows of A/C
K_size_i  in  SizeWidth  inner dimension
N_size_i  in  SizeWidth  columns of B/C
sram_a_addr_o  out  SRAMAddrWidthA  A element address (m*K+k)
sram_a_rdata_i  in  DataWidthA  A[addr], combinational same cycle
sram_b_addr_o  out  SRAMAddrWidthB  B address of lane 0 (k*N+n0)
sram_b_rdata_i  in  NumLanes*DataWidthB  lane l at bits [l*DataWidthB +: DataWidthB] = B[addr+l]; same cycle
sram_c_addr_o  out  SRAMAddrWidthC  C address of lane 0 (m*N+n0)
sram_c_wdata_o  out  NumLanes*DataWidthC  lane-packed results
sram_c_we_o  out  NumLanes  per-lane write enable
busy_o  out  1  high in MAC/WRITE
done_o  out  1  level; high in DONE

Behaviour:
- Reset (async): state=IDLE. All addresses 0, wdata 0, we 0, busy_o 0, done_o 0. Accumulators 0.
- States: IDLE, MAC, WRITE, DONE.
- IDLE/DONE with start_i=1 at a clock edge: latch M/K/N. Clear m, tile index t, k, and accumulators. Next state is MAC. If any latched size is 0, next state is DONE, with no SRAM writes.
- start_i is ignored in MAC/WRITE. Sizes are sampled only on the accepting edge; later changes have no effect.
- MAC, one cycle per k:
  - a_addr = m*K+k; b_addr = k*N+t*NumLanes.
  - Every lane does acc_l += sext(A)*sext(B_l), wrapping modulo 2^DataWidthC.
  - At k=K-1 the next state is WRITE.
- Addresses are generated by incremental counters: a_addr += 1; b_addr += N per k. Results are truncated to port widths; wrap-around is silent.
- WRITE, one cycle:
  - c_addr = m*N+t*NumLanes; wdata = acc lanes.
  - we[l] = (t*NumLanes+l < N). Partial last tile masks the upper lanes.
  - Accumulators clear; k returns to 0.
  - Advance t. When t wraps past ceil(N/NumLanes)-1, advance m.
  - When m passes M-1, next state is DONE; otherwise MAC.
- Lanes beyond N still accumulate whatever is on their B input. Their results are never written.
- DONE: done_o=1 and sram_c_we_o=0. done_o is held until a start is accepted (done_o drops on that edge) or reset.
- Latency: start-accept edge to done_o rising = M*ceil(N/NumLanes)*(K+1) cycles.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values; the partial C contents are undefined.
- sram_c_we_o is 0 in every state except WRITE.

Decomposition:
- Package gemm_pkg:
  - state enum (IDLE, MAC, WRITE, DONE)
  - lane count/width localparams
  - helper function for ceil-div tile count
- Sub-module gemm_mac_lane, instantiated NumLanes times:
  - signed multiply-accumulate register
  - clear and enable inputs
  - DataWidthC output
- Top holds the FSM, counters, address generators and write-mask logic.

Test Plan:
1. M=K=N=1, A=0x7F, B=0x80, NumLanes=4 -> one write: C[0]=0xFFFFC080 (-16256), we=4'b0001, done_o after 2 cycles.
2. M=2,K=3,N=4, random signed data -> C matches golden exactly, we=4'b1111 each write. Latency 2*1*4=8 cycles.
3. M=3,K=2,N=5 -> second tile we=4'b0001 at c_addr=m*5+4. C entries 15..end untouched (pre-filled 0xDEADBEEF remains).
4. M=1,K=32,N=4, all A=-128, B=-128 -> each C=524288 (0x00080000). Then a repeat with DataWidthC=16 -> 0x0000 (wrap).
5. N_size_i=0 with start -> DONE next cycle, done_o=1, no we pulses. Re-start with M=K=N=2 -> done_o drops on accept, correct result.
6. rst_ni low mid-MAC in a 32×32×32 run -> outputs reset asynchronously. After release, start_i while busy is ignored, and a fresh run completes with golden-match.
